// File: rtl/dsc_stream_decoder.sv
// dsc_stream_decoder: counts ones in a serial stochastic frame of up to 2^W bits
// and presents the count and frame length over a valid/ready handshake.
module dsc_stream_decoder #(
    parameter int SNG_WIDTH  = 6,
    parameter int NUM_INPUTS = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             sn_in,
    input  logic                             sn_valid,
    input  logic                             eos,
    output logic                             in_ready,
    output logic                             busy,
    output logic [NUM_INPUTS*SNG_WIDTH:0]    z,
    output logic [NUM_INPUTS*SNG_WIDTH:0]    frame_len,
    output logic                             z_valid,
    input  logic                             z_ready
);
    localparam int W = NUM_INPUTS * SNG_WIDTH;
    localparam logic [W:0] L = (W+1)'(1) << W;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t     state, state_nxt;
    logic [W:0] ones, bits, ones_nxt, bits_nxt, ones_acc, bits_acc;
    logic       take, load;

    // the bit taken in the closing cycle (L-th bit or alongside eos) is part of the result
    always_comb begin
        take      = (state == ACCUM) && sn_valid;
        ones_acc  = ones + (W+1)'(take && sn_in);
        bits_acc  = bits + (W+1)'(take);
        state_nxt = state;
        ones_nxt  = ones;
        bits_nxt  = bits;
        load      = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_nxt = ACCUM;
                ones_nxt  = '0;
                bits_nxt  = '0;
            end
            ACCUM: begin
                ones_nxt = ones_acc;
                bits_nxt = bits_acc;
                if (eos || bits_acc == L) begin
                    state_nxt = HOLD;
                    load      = 1'b1;
                end
            end
            HOLD: if (z_ready) begin
                state_nxt = start ? ACCUM : IDLE;
                ones_nxt  = '0;
                bits_nxt  = '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ones      <= '0;
            bits      <= '0;
            z         <= '0;
            frame_len <= '0;
        end else begin
            state <= state_nxt;
            ones  <= ones_nxt;
            bits  <= bits_nxt;
            if (load) begin
                z         <= ones_acc;
                frame_len <= bits_acc;
            end
        end
    end

    assign in_ready = (state == ACCUM);
    assign busy     = (state != IDLE);
    assign z_valid  = (state == HOLD);
endmodule

// File: tb/tb_dsc_stream_decoder.sv
// tb_dsc_stream_decoder: directed and randomized frames checked against a
// queue-based model of accepted bits (W=4, L=16).
module tb_dsc_stream_decoder;
    localparam int SW = 2;
    localparam int NI = 2;
    localparam int W  = SW * NI;
    localparam int L  = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0, sn_in = 1'b0, sn_valid = 1'b0, eos = 1'b0, z_ready = 1'b0;
    logic         in_ready, busy, z_valid;
    logic [W:0]   z, frame_len;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_z   = 0;
    int exp_len = 0;
    bit chained = 1'b0;

    dsc_stream_decoder #(.SNG_WIDTH(SW), .NUM_INPUTS(NI)) dut (
        .clk(clk), .rst(rst), .start(start), .sn_in(sn_in), .sn_valid(sn_valid),
        .eos(eos), .in_ready(in_ready), .busy(busy), .z(z), .frame_len(frame_len),
        .z_valid(z_valid), .z_ready(z_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag);
        check({tag, "_zv"},  32'(z_valid),   1);
        check({tag, "_z"},   32'(z),         32'(exp_z));
        check({tag, "_len"}, 32'(frame_len), 32'(exp_len));
        check({tag, "_rdy"}, 32'(in_ready),  0);
        check({tag, "_bsy"}, 32'(busy),      1);
    endtask

    // modes: 0 all ones, 1 alternating with gaps, 2 fixed 5-bit eos, 3 random, 4 immediate eos
    task automatic do_frame(input int mode, input int eos_at);
        bit q[$];
        int pat[5] = '{1, 1, 0, 1, 0};
        int cyc = 0;
        bit done = 1'b0;
        bit v, b, e;
        if (!chained) begin
            start = 1'b1;
            step();
            start = 1'b0;
        end
        chained = 1'b0;
        while (!done && cyc < 100) begin
            case (mode)
                0:       begin v = 1'b1; b = 1'b1; e = 1'b0; end
                1:       begin v = (cyc % 3 != 2); b = (q.size() % 2 == 0); e = 1'b0; end
                2:       begin v = 1'b1; b = pat[cyc][0]; e = (cyc == 4); end
                4:       begin v = 1'b0; b = 1'($urandom); e = 1'b1; end
                default: begin v = ($urandom % 4 != 0); b = 1'($urandom); e = (cyc == eos_at); end
            endcase
            sn_valid = v;
            sn_in    = v ? b : 1'($urandom);
            eos      = e;
            start    = (mode == 3) ? 1'($urandom) : 1'b0;
            check("accum_rdy", 32'(in_ready), 1);
            if (v) q.push_back(b);
            if (q.size() == L || e) done = 1'b1;
            step();
            cyc++;
        end
        sn_valid = 1'b0;
        eos = 1'b0;
        start = 1'b0;
        if (!done) check("frame_timeout", 0, 1);
        exp_len = q.size();
        exp_z = 0;
        foreach (q[i]) exp_z += int'(q[i]);
        check_result($sformatf("frame_m%0d", mode));
    endtask

    task automatic hold(input int n, input bit with_start);
        for (int i = 0; i < n; i++) begin
            z_ready  = 1'b0;
            start    = 1'($urandom);
            sn_valid = 1'($urandom);
            sn_in    = 1'(i);
            eos      = 1'($urandom);
            step();
            check_result("hold");
        end
        sn_valid = 1'b0;
        eos = 1'b0;
        z_ready = 1'b1;
        start = with_start;
        step();
        z_ready = 1'b0;
        start = 1'b0;
        check("rel_zv",  32'(z_valid),   0);
        check("rel_rdy", 32'(in_ready),  32'(with_start));
        check("rel_bsy", 32'(busy),      32'(with_start));
        check("rel_z",   32'(z),         32'(exp_z));
        check("rel_len", 32'(frame_len), 32'(exp_len));
        chained = with_start;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_bsy"}, 32'(busy),     0);
        check({tag, "_rdy"}, 32'(in_ready), 0);
        check({tag, "_zv"},  32'(z_valid),  0);
    endtask

    initial begin
        #12;
        check_idle("rst");
        check("rst_z",   32'(z),         0);
        check("rst_len", 32'(frame_len), 0);
        rst = 1'b1;
        step();
        check_idle("idle");

        do_frame(0, 0);
        check("ones16_z", 32'(z), 16);
        hold(2, 1'b0);
        do_frame(1, 0);
        check("alt_z", 32'(z), 8);
        hold(10, 1'b1);
        do_frame(3, 9);
        hold(1, 1'b0);
        do_frame(2, 0);
        check("eos5_len", 32'(frame_len), 5);
        hold(0, 1'b0);
        do_frame(4, 0);
        check("eos0_len", 32'(frame_len), 0);
        hold(1, 1'b0);

        // asynchronous reset mid-frame after 7 accepted bits
        start = 1'b1;
        step();
        start = 1'b0;
        sn_valid = 1'b1;
        sn_in = 1'b1;
        repeat (7) step();
        sn_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_idle("arst");
        check("arst_z",   32'(z),         0);
        check("arst_len", 32'(frame_len), 0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            eos = 1'b1;
            sn_valid = 1'b1;
            sn_in = 1'b1;
            step();
            check_idle("post_rst");
        end
        eos = 1'b0;
        sn_valid = 1'b0;
        chained = 1'b0;

        for (int k = 0; k < 25; k++) begin
            do_frame(3, int'($urandom_range(0, 25)));
            hold(int'($urandom_range(0, 4)), 1'($urandom));
        end
        if (chained) begin
            do_frame(3, 40);
            hold(0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dsc_stream_decoder.md
DSC_STREAM_DECODER -- requirements
Module: dsc_stream_decoder

Interface
REQ-001 Parameter SNG_WIDTH, default 6, per-input SNG width in bits.
REQ-002 Parameter NUM_INPUTS, default 4, number of multiplied operands; define W = NUM_INPUTS*SNG_WIDTH and full frame length L = 2^W bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous assert, active-low (rst=0 resets).
REQ-005 start  input  1  request to open a new frame.
REQ-006 sn_in  input  1  serial stochastic product bit.
REQ-007 sn_valid  input  1  sn_in is valid this cycle.
REQ-008 eos  input  1  early end-of-stream from the producer; closes the current frame.
REQ-009 in_ready  output  1  decoder is accepting stream bits (high only in ACCUM).
REQ-010 busy  output  1  high in ACCUM or HOLD.
REQ-011 z  output  W+1  count of ones in the closed frame.
REQ-012 frame_len  output  W+1  number of bits accepted in the closed frame.
REQ-013 z_valid  output  1  z and frame_len hold a result.
REQ-014 z_ready  input  1  consumer accepts the result.

Function
REQ-015 Block SHALL be the receiving end of a serial stochastic product stream: it SHALL count the ones in a frame of up to L accepted bits and present the binary count over a valid/ready handshake.
REQ-016 A bit SHALL be accepted in a cycle when state=ACCUM and sn_valid=1; sn_in and sn_valid SHALL be ignored in IDLE and HOLD.
REQ-017 FSM states SHALL be IDLE, ACCUM and HOLD, with one-state-per-cycle transitions.
REQ-018 IDLE: start=1 -> ACCUM next cycle; ones counter and bit counter SHALL be cleared to 0 on that transition.
REQ-019 ACCUM: each accepted bit SHALL increment the bit counter by 1, and SHALL increment the ones counter by 1 when sn_in=1; both counters are W+1 bits wide and SHALL never wrap.
REQ-020 ACCUM: frame SHALL close when the accepted bit is the L-th bit, or when eos=1 in any ACCUM cycle; a bit accepted in the same cycle as eos SHALL be counted.
REQ-021 On frame close, the next cycle SHALL be HOLD, with z = final ones count, frame_len = final bit count and z_valid = 1; latency is one cycle from the last accepted bit (or eos) to z_valid.
REQ-022 eos with zero bits accepted SHALL close the frame with z=0 and frame_len=0.
REQ-023 HOLD: z, frame_len and z_valid SHALL be held stable until a cycle with z_ready=1.
REQ-024 HOLD with z_ready=1 -> IDLE next cycle, z_valid cleared; if start=1 in the same cycle -> ACCUM directly, counters cleared, z_valid cleared.
REQ-025 start SHALL be ignored in ACCUM and HOLD except as in REQ-024; eos SHALL be ignored in IDLE and HOLD.
REQ-026 z and frame_len SHALL change only on entry to HOLD or on reset; they SHALL keep their last values in IDLE and ACCUM.
REQ-027 Invariant: z <= frame_len <= L at all times.

Reset
REQ-028 rst=0 SHALL immediately force state=IDLE, both counters=0, z=0, frame_len=0, z_valid=0, in_ready=0 and busy=0, regardless of clock.
REQ-029 Reset during ACCUM or HOLD SHALL discard the frame or result with no output; a new start is required after rst returns to 1.

Verification (run with SNG_WIDTH=2, NUM_INPUTS=2, so W=4 and L=16)
REQ-030 start, then 16 consecutive valid bits of sn_in=1 -> z_valid the cycle after the 16th bit, z=16, frame_len=16, in_ready=0.
REQ-031 start, alternating 1/0 bits with sn_valid low on every third cycle -> z=8, frame_len=16; bits during sn_valid=0 are not counted.
REQ-032 start, 5 valid bits 1,1,0,1,0 with eos=1 on the 5th -> z=3, frame_len=5, z_valid one cycle later.
REQ-033 Result in HOLD with z_ready=0 for 10 cycles while sn_in toggles -> z and frame_len stable, in_ready=0; then z_ready=1 and start=1 together -> ACCUM next cycle, z_valid=0, fresh frame counts from 0.
REQ-034 rst=0 after 7 accepted bits in ACCUM -> all outputs 0 asynchronously, state IDLE; eos or sn_valid in IDLE afterwards -> no state change.
REQ-035 start then eos=1 immediately with no valid bits -> z=0, frame_len=0, z_valid=1.
